// File: rtl/ham_decoder_pipe_if.sv
// Valid/ready stream bundle for the Hamming(7,4) decoder: codeword in, corrected data out.
interface ham_decoder_pipe_if;
    logic [6:0] enc_ham_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data;
    logic [2:0] syndrome;
    logic       err_flag;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output enc_ham_data, in_valid, out_ready,
        input  in_ready, data, syndrome, err_flag, out_valid
    );

    modport slave (
        input  enc_ham_data, in_valid, out_ready,
        output in_ready, data, syndrome, err_flag, out_valid
    );
endinterface

// File: rtl/ham_decoder_pipe.sv
// Two-stage Hamming(7,4) single-error-correcting decoder with full backpressure
// and saturating delivered/corrected word counters.
module ham_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ham_decoder_pipe_if.slave bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       r_s1_valid;
    logic [6:0] r_s1_code;
    logic [2:0] r_s1_syn;
    logic       r_s2_valid;
    logic [3:0] r_data;
    logic [2:0] r_syn;
    logic       r_err;

    logic       w_s2_adv;
    logic       w_s1_adv;
    logic       w_accept;
    logic       w_deliver;
    logic [2:0] w_syn;
    logic [6:0] w_flip;
    logic [6:0] w_fixed;

    assign w_s2_adv  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_accept  = bus.in_valid && w_s1_adv;
    assign w_deliver = r_s2_valid && bus.out_ready;

    assign w_syn = {bus.enc_ham_data[3] ^ bus.enc_ham_data[4] ^ bus.enc_ham_data[5] ^ bus.enc_ham_data[6],
                    bus.enc_ham_data[1] ^ bus.enc_ham_data[2] ^ bus.enc_ham_data[5] ^ bus.enc_ham_data[6],
                    bus.enc_ham_data[0] ^ bus.enc_ham_data[2] ^ bus.enc_ham_data[4] ^ bus.enc_ham_data[6]};

    // Syndrome k points at codeword position k, i.e. bit index k-1.
    always_comb begin
        w_flip = '0;
        if (r_s1_syn != 3'd0) begin
            w_flip = 7'd1 << (r_s1_syn - 3'd1);
        end
        w_fixed = r_s1_code ^ w_flip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_code <= bus.enc_ham_data;
                r_s1_syn  <= w_syn;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_data     <= '0;
            r_syn      <= '0;
            r_err      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data <= {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
                r_syn  <= r_s1_syn;
                r_err  <= (r_s1_syn != 3'd0);
            end
        end
    end

    // A clear wins over the increment on the same edge; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (clr_cnt) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (w_deliver) begin
            if (word_cnt != '1) begin
                word_cnt <= word_cnt + CNT_ONE;
            end
            if (r_err && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + CNT_ONE;
            end
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.data      = r_data;
    assign bus.syndrome  = r_syn;
    assign bus.err_flag  = r_err;
    assign bus.out_valid = r_s2_valid;

endmodule

// File: tb/tb_ham_decoder_pipe.sv
// Directed bench for ham_decoder_pipe: decode vectors, backpressure stream,
// counter saturation/clear (CNT_W=2 instance) and asynchronous reset.
module tb_ham_decoder_pipe;

    logic        clk;
    logic        rst_n;
    logic        clrCnt;
    logic        clrCntSat;
    logic [15:0] wordCnt;
    logic [15:0] corrCnt;
    logic [1:0]  wordCntSat;
    logic [1:0]  corrCntSat;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] delivered[$];
    logic [6:0] streamWords[4];
    logic [3:0] streamExp[4];

    ham_decoder_pipe_if bus ();
    ham_decoder_pipe_if busSat ();

    ham_decoder_pipe #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .clr_cnt  (clrCnt),
        .word_cnt (wordCnt),
        .corr_cnt (corrCnt)
    );

    ham_decoder_pipe #(.CNT_W(2)) dutSat (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (busSat.slave),
        .clr_cnt  (clrCntSat),
        .word_cnt (wordCntSat),
        .corr_cnt (corrCntSat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            delivered.push_back(bus.data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One word through an otherwise idle pipe with out_ready held high; entered at posedge+1.
    task automatic applyStimulus(input logic [6:0] code, input logic [3:0] expData,
                                 input logic [2:0] expSyn, input int expWord, input int expCorr);
        bus.enc_ham_data = code;
        bus.in_valid     = 1'b1;
        bus.out_ready    = 1'b1;
        #1;
        checkOutput("in_ready_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("valid_too_early", bus.out_valid, 0);
        @(posedge clk); #1;
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("data", bus.data, expData);
        checkOutput("syndrome", bus.syndrome, expSyn);
        checkOutput("err_flag", bus.err_flag, (expSyn != 3'd0));
        @(posedge clk); #1;
        checkOutput("word_cnt", wordCnt, expWord);
        checkOutput("corr_cnt", corrCnt, expCorr);
        checkOutput("drained", bus.out_valid, 0);
    endtask

    initial begin
        logic acc;
        int   idx;

        rst_n               = 1'b0;
        clrCnt              = 1'b0;
        clrCntSat           = 1'b0;
        bus.enc_ham_data    = '0;
        bus.in_valid        = 1'b0;
        bus.out_ready       = 1'b1;
        busSat.enc_ham_data = '0;
        busSat.in_valid     = 1'b0;
        busSat.out_ready    = 1'b1;
        streamWords = '{7'h00, 7'h7F, 7'h55, 7'h45};
        streamExp   = '{4'h0, 4'hF, 4'hB, 4'hB};

        #12;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_data", bus.data, 0);
        checkOutput("rst_word_cnt", wordCnt, 0);
        checkOutput("rst_corr_cnt", corrCnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(7'h55, 4'hB, 3'd0, 1, 0);
        applyStimulus(7'h45, 4'hB, 3'd5, 2, 1);
        applyStimulus(7'h54, 4'hB, 3'd1, 3, 2);
        applyStimulus(7'h56, 4'hA, 3'd3, 4, 3);
        applyStimulus(7'h7F, 4'hF, 3'd0, 5, 3);

        // Backpressure stream: out_ready low for cycles 2..4.
        clrCnt = 1'b1;
        @(posedge clk); #1;
        clrCnt = 1'b0;
        delivered.delete();
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            bus.in_valid  = (idx < 4);
            if (idx < 4) bus.enc_ham_data = streamWords[idx];
            #1;
            if (c >= 2 && c <= 4) begin
                checkOutput("stall_in_ready", bus.in_ready, 0);
                checkOutput("stall_out_valid", bus.out_valid, 1);
                checkOutput("stall_data", bus.data, 4'h0);
                checkOutput("stall_syndrome", bus.syndrome, 3'd0);
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("stream_accepted", idx, 4);
        checkOutput("stream_count", delivered.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stream_order", (i < delivered.size()) ? delivered[i] : 4'hx, streamExp[i]);
        end
        checkOutput("stream_word_cnt", wordCnt, 4);
        checkOutput("stream_corr_cnt", corrCnt, 1);

        // Clear coinciding with the delivery of an errored word.
        bus.enc_ham_data = 7'h45;
        bus.in_valid     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("clr_pre_valid", bus.out_valid, 1);
        clrCnt = 1'b1;
        @(posedge clk); #1;
        clrCnt = 1'b0;
        checkOutput("clr_word_cnt", wordCnt, 0);
        checkOutput("clr_corr_cnt", corrCnt, 0);
        checkOutput("clr_delivered", bus.out_valid, 0);

        // Saturation on the CNT_W=2 instance: five errored words.
        busSat.enc_ham_data = 7'h45;
        busSat.in_valid     = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        busSat.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat_word_cnt", wordCntSat, 3);
        checkOutput("sat_corr_cnt", corrCntSat, 3);

        applyStimulus(7'h45, 4'hB, 3'd5, 1, 1);

        // Async reset with two words held in the stalled pipe.
        bus.out_ready    = 1'b0;
        bus.enc_ham_data = 7'h55;
        bus.in_valid     = 1'b1;
        @(posedge clk); #1;
        bus.enc_ham_data = 7'h7F;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("inflight_valid", bus.out_valid, 1);
        checkOutput("inflight_in_ready", bus.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", bus.out_valid, 0);
        checkOutput("async_word_cnt", wordCnt, 0);
        checkOutput("async_corr_cnt", corrCnt, 0);
        checkOutput("async_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_empty", bus.out_valid, 0);
        applyStimulus(7'h55, 4'hB, 3'd0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
